rr_select_scheduler: RTL and testbench

- Round-robin scheduler that sits directly upstream of the 3-input select mux.
- Arbitrates between three requesters and drives the mux's 2-bit select code: 01 selects B1, 10 selects B2, 11 selects B3, 00 forces the output to 0.
- Bounds each grant to a maximum length.
- Guarantees a programmable number of idle (00) cycles between grants.

---
 rtl/rr_select_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_rr_select_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_select_scheduler.sv
// ---------------------------------------------------------------------------
// rr_select_scheduler
// Round-robin scheduler driving the 2-bit select code of a 3-input mux.
//   sel = 01 -> B1, 10 -> B2, 11 -> B3, 00 -> mux output forced to zero.
// Each grant is bounded to MAX_HOLD cycles, and every grant is followed by
// exactly IDLE_GAP cycles of sel = 00 before the next arbitration.
// The grant-release input is named release_grant because "release" is a
// reserved word in SystemVerilog.
// ---------------------------------------------------------------------------
module rr_select_scheduler #(
    parameter int MAX_HOLD = 8,   // 1..255
    parameter int IDLE_GAP = 1    // 1..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic       release_grant,
    output logic [1:0] sel,
    output logic [2:0] grant,
    output logic       busy,
    output logic       timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    localparam logic [3:0] GAP_LIMIT  = 4'(IDLE_GAP);

    // Round-robin pick: search starts one past the last-served requester and
    // wraps. Result is {found, index}.
    function automatic logic [2:0] arb_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        logic [2:0] res;
        case (last)
            2'd0: begin
                c0 = 2'd1; c1 = 2'd2; c2 = 2'd0;
            end
            2'd1: begin
                c0 = 2'd2; c1 = 2'd0; c2 = 2'd1;
            end
            default: begin
                c0 = 2'd0; c1 = 2'd1; c2 = 2'd2;
            end
        endcase
        if (r[c0]) begin
            res = {1'b1, c0};
        end else if (r[c1]) begin
            res = {1'b1, c1};
        end else if (r[c2]) begin
            res = {1'b1, c2};
        end else begin
            res = {1'b0, 2'd0};
        end
        return res;
    endfunction

    // Requester index to one-hot grant vector; out-of-range index gives 000.
    function automatic logic [2:0] to_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Request line of a given requester; out-of-range index reads as idle.
    function automatic logic req_of(input logic [2:0] r, input logic [1:0] idx);
        logic v;
        case (idx)
            2'd0:    v = r[0];
            2'd1:    v = r[1];
            2'd2:    v = r[2];
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    // Registered state
    logic [1:0] state_r;
    logic [7:0] hold_r;
    logic [3:0] gap_r;
    logic [1:0] last_r;
    logic [1:0] owner_r;
    logic [1:0] sel_r;
    logic [2:0] grant_r;
    logic       busy_r;
    logic       timeout_r;

    // Next-state values
    logic [1:0] state_s;
    logic [7:0] hold_s;
    logic [3:0] gap_s;
    logic [1:0] last_s;
    logic [1:0] owner_s;
    logic [1:0] sel_s;
    logic [2:0] grant_s;
    logic       busy_s;
    logic       timeout_s;

    // Arbitration and grant-exit decode
    logic [2:0] pick_s;
    logic       win_valid_s;
    logic [1:0] win_idx_s;
    logic       owner_req_s;
    logic       limit_s;
    logic       exit_s;
    logic       limit_only_s;

    // Decode the round-robin winner and the reasons a running grant may end.
    always_comb begin
        pick_s       = arb_pick(req, last_r);
        win_valid_s  = pick_s[2];
        win_idx_s    = pick_s[1:0];
        owner_req_s  = req_of(req, owner_r);
        limit_s      = (hold_r == HOLD_LIMIT);
        exit_s       = release_grant | ~owner_req_s | limit_s;
        // A timeout is reported only when the hold limit is the sole cause.
        limit_only_s = limit_s & ~release_grant & owner_req_s;
    end

    // Next-state logic: IDLE -> GRANT -> GAP -> (GRANT | IDLE).
    always_comb begin
        state_s = state_r;
        hold_s  = hold_r;
        gap_s   = gap_r;
        last_s  = last_r;
        owner_s = owner_r;
        case (state_r)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_s = ST_GRANT;
                    owner_s = win_idx_s;
                    hold_s  = 8'd1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (exit_s) begin
                    state_s = ST_GAP;
                    last_s  = owner_r;
                    gap_s   = 4'd1;
                    hold_s  = 8'd0;
                end else begin
                    hold_s  = hold_r + 8'd1;
                end
            end
            ST_GAP: begin
                if (gap_r == GAP_LIMIT) begin
                    gap_s = 4'd0;
                    if (win_valid_s) begin
                        state_s = ST_GRANT;
                        owner_s = win_idx_s;
                        hold_s  = 8'd1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    gap_s = gap_r + 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                hold_s  = 8'd0;
                gap_s   = 4'd0;
            end
        endcase
    end

    // Output decode from the next state, so every output leaves a register.
    always_comb begin
        sel_s     = 2'b00;
        grant_s   = 3'b000;
        busy_s    = 1'b0;
        timeout_s = 1'b0;
        if (state_s == ST_GRANT) begin
            sel_s   = owner_s + 2'd1;
            grant_s = to_onehot(owner_s);
            busy_s  = 1'b1;
        end else begin
            sel_s   = 2'b00;
            grant_s = 3'b000;
            busy_s  = 1'b0;
        end
        if ((state_r == ST_GRANT) && exit_s && limit_only_s) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            hold_r    <= 8'd0;
            gap_r     <= 4'd0;
            last_r    <= 2'd2;
            owner_r   <= 2'd0;
            sel_r     <= 2'b00;
            grant_r   <= 3'b000;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            hold_r    <= hold_s;
            gap_r     <= gap_s;
            last_r    <= last_s;
            owner_r   <= owner_s;
            sel_r     <= sel_s;
            grant_r   <= grant_s;
            busy_r    <= busy_s;
            timeout_r <= timeout_s;
        end
    end

    assign sel     = sel_r;
    assign grant   = grant_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_rr_select_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for rr_select_scheduler. Two instances share the same stimulus:
// index 0 uses MAX_HOLD=4/IDLE_GAP=1, index 1 uses MAX_HOLD=4/IDLE_GAP=3.
// A behavioural model predicts every output each cycle; directed literal
// expectations pin the model to hand-derived sequences.
// ---------------------------------------------------------------------------
module tb_rr_select_scheduler;

    localparam int MAXH = 4;
    localparam int GAPS [2] = '{1, 3};

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic       rel;

    logic [1:0] sel_a   [2];
    logic [2:0] grant_a [2];
    logic       busy_a  [2];
    logic       to_a    [2];

    int tests = 0;
    int fails = 0;

    rr_select_scheduler #(.MAX_HOLD(4), .IDLE_GAP(1)) dut_g1 (
        .clk(clk), .reset(rst), .req(req), .release_grant(rel),
        .sel(sel_a[0]), .grant(grant_a[0]), .busy(busy_a[0]), .timeout(to_a[0])
    );

    rr_select_scheduler #(.MAX_HOLD(4), .IDLE_GAP(3)) dut_g3 (
        .clk(clk), .reset(rst), .req(req), .release_grant(rel),
        .sel(sel_a[1]), .grant(grant_a[1]), .busy(busy_a[1]), .timeout(to_a[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = waiting for requests, 1 = someone owns the mux, 2 = resting
    int   m_mode  [2];
    int   m_owner [2];
    int   m_age   [2];   // cycles the current owner has held the mux
    int   m_rest  [2];   // idle cycles already spent after a grant
    int   m_last  [2];
    logic m_to    [2];
    logic m_valid = 1'b0;

    function automatic int rr_pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (r[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                int w;
                if (rst) begin
                    m_mode[i] = 0; m_owner[i] = 0; m_age[i] = 0;
                    m_rest[i] = 0; m_last[i] = 2; m_to[i] = 1'b0;
                    m_valid = 1'b1;
                end else if (m_mode[i] == 1) begin
                    m_to[i] = 1'b0;
                    if (rel || !req[m_owner[i]] || m_age[i] == MAXH) begin
                        m_to[i]   = (m_age[i] == MAXH) && !rel && req[m_owner[i]];
                        m_last[i] = m_owner[i];
                        m_mode[i] = 2;
                        m_rest[i] = 1;
                    end else begin
                        m_age[i]++;
                    end
                end else begin
                    m_to[i] = 1'b0;
                    if (m_mode[i] == 0 || m_rest[i] == GAPS[i]) begin
                        w = rr_pick(req, m_last[i]);
                        if (w >= 0) begin
                            m_mode[i] = 1; m_owner[i] = w; m_age[i] = 1;
                        end else begin
                            m_mode[i] = 0;
                        end
                    end else begin
                        m_rest[i]++;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                for (int i = 0; i < 2; i++) begin
                    logic [1:0] es;
                    logic [2:0] eg;
                    es = (m_mode[i] == 1) ? 2'(m_owner[i] + 1) : 2'b00;
                    eg = (m_mode[i] == 1) ? (3'b001 << m_owner[i]) : 3'b000;
                    chk($sformatf("model_sel[%0d]", i),   8'(sel_a[i]),   8'(es));
                    chk($sformatf("model_grant[%0d]", i), 8'(grant_a[i]), 8'(eg));
                    chk($sformatf("model_busy[%0d]", i),  8'(busy_a[i]),  8'(m_mode[i] == 1));
                    chk($sformatf("model_to[%0d]", i),    8'(to_a[i]),    8'(m_to[i]));
                end
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    logic [1:0] t1_sel [21] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0,
                                2'd2, 2'd2, 2'd2, 2'd2, 2'd0,
                                2'd3, 2'd3, 2'd3, 2'd3, 2'd0,
                                2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2};

    task automatic pulse_reset();
        rst = 1'b1; req = 3'b000; rel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 3'b000; rel = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_sel",   8'(sel_a[i]),   8'h00);
            chk("reset_grant", 8'(grant_a[i]), 8'h00);
            chk("reset_busy",  8'(busy_a[i]),  8'h00);
            chk("reset_to",    8'(to_a[i]),    8'h00);
        end

        // Test 1: continuous request from all three, hold limit rotation.
        rst = 1'b0; req = 3'b111;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            chk($sformatf("t1_sel[%0d]", k), 8'(sel_a[0]), 8'(t1_sel[k]));
            chk($sformatf("t1_to[%0d]", k),  8'(to_a[0]),  8'(t1_sel[k] == 2'd0));
        end

        // Test 5: reset during requester 1's grant.
        rst = 1'b1;
        @(negedge clk);
        chk("t5_sel",   8'(sel_a[0]),   8'h00);
        chk("t5_grant", 8'(grant_a[0]), 8'h00);
        chk("t5_busy",  8'(busy_a[0]),  8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_first", 8'(sel_a[0]), 8'h01);

        // Test 2: release in the second grant cycle.
        pulse_reset();
        req = 3'b010;
        @(negedge clk); chk("t2_n1", 8'(sel_a[0]), 8'h02);
        @(negedge clk); chk("t2_n2", 8'(sel_a[0]), 8'h02);
        rel = 1'b1;
        @(negedge clk); chk("t2_n3", 8'(sel_a[0]), 8'h00); chk("t2_to", 8'(to_a[0]), 8'h00);
        rel = 1'b0;
        @(negedge clk); chk("t2_n4", 8'(sel_a[0]), 8'h02);

        // Test 3: owner drops its request.
        pulse_reset();
        req = 3'b001;
        @(negedge clk); chk("t3_n1", 8'(sel_a[0]), 8'h01);
        @(negedge clk); chk("t3_n2", 8'(sel_a[0]), 8'h01);
        req = 3'b000;
        @(negedge clk); chk("t3_n3", 8'(sel_a[0]), 8'h00); chk("t3_busy", 8'(busy_a[0]), 8'h00);
        chk("t3_to", 8'(to_a[0]), 8'h00);
        @(negedge clk); chk("t3_n4", 8'(sel_a[0]), 8'h00);
        @(negedge clk); chk("t3_n5", 8'(sel_a[0]), 8'h00);

        // Test 4: release coincides with the hold limit.
        pulse_reset();
        req = 3'b001;
        repeat (4) @(negedge clk);
        chk("t4_n4", 8'(sel_a[0]), 8'h01);
        rel = 1'b1;
        @(negedge clk); chk("t4_sel", 8'(sel_a[0]), 8'h00); chk("t4_to", 8'(to_a[0]), 8'h00);
        rel = 1'b0;
        @(negedge clk); chk("t4_again", 8'(sel_a[0]), 8'h01);

        // Test 6: fairness, IDLE_GAP=1 and IDLE_GAP=3.
        pulse_reset();
        req = 3'b101;
        @(negedge clk);
        chk("t6_g1_first", 8'(sel_a[0]), 8'h01);
        chk("t6_g3_first", 8'(sel_a[1]), 8'h01);
        rel = 1'b1;
        @(negedge clk);
        chk("t6_g1_gap",  8'(sel_a[0]), 8'h00);
        chk("t6_g3_gap1", 8'(sel_a[1]), 8'h00);
        chk("t6_g3_to",   8'(to_a[1]),  8'h00);
        rel = 1'b0;
        @(negedge clk);
        chk("t6_g1_next", 8'(sel_a[0]), 8'h03);
        chk("t6_g3_gap2", 8'(sel_a[1]), 8'h00);
        @(negedge clk);
        chk("t6_g3_gap3", 8'(sel_a[1]), 8'h00);
        @(negedge clk);
        chk("t6_g3_next", 8'(sel_a[1]), 8'h03);

        req = 3'b000;
        repeat (8) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
